// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one bit per clock, fixed XLEN+1 cycle latency.
// Define MDU_DIV_EN to build the restoring divider; otherwise divide ops return 0 after one cycle.
module mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned   CW       = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] acc_hi, acc_lo;

  // MULHSU treats only src_a as signed; the U variants treat neither.
  always_comb begin
    a_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_sgn = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg = a_sgn & src_a[XLEN-1];
    b_neg = b_sgn & src_b[XLEN-1];
    mag_a = a_neg ? -src_a : src_a;
    mag_b = b_neg ? -src_b : src_b;
  end

  assign acc_hi = acc_q[2*XLEN-1:XLEN];
  assign acc_lo = acc_q[XLEN-1:0];

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right with carry.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;
  logic [2*XLEN-1:0] step_acc;

  assign mul_sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opb_q}) : {1'b0, acc_hi};
  assign mul_acc = {mul_sum, acc_lo[XLEN-1:1]};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   fix_res;

  assign prod    = neg_q ? -acc_q : acc_q;
  assign mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef MDU_DIV_EN
  logic sa_q, sa_d;
  logic bz_q, bz_d;

  // Divide: acc = {remainder, dividend/quotient}; quotient bits shift in at the bottom.
  logic [XLEN:0]     div_shl;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] div_acc;
  logic [XLEN-1:0]   quot, rem;

  assign div_shl = {acc_hi, acc_lo[XLEN-1]};
  assign div_ge  = div_shl >= {1'b0, opb_q};
  assign div_sub = div_shl[XLEN-1:0] - opb_q;
  assign div_acc = div_ge ? {div_sub, acc_lo[XLEN-2:0], 1'b1}
                          : {div_shl[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};

  assign step_acc = op_q[2] ? div_acc : mul_acc;

  // Divide-by-zero leaves |a| in the remainder, so only the quotient needs forcing;
  // min-int / -1 falls out of the magnitude datapath unchanged.
  assign quot    = bz_q ? '1 : (neg_q ? -acc_lo : acc_lo);
  assign rem     = sa_q ? -acc_hi : acc_hi;
  assign fix_res = op_q[2] ? (op_q[1] ? rem : quot) : mul_res;
`else
  assign step_acc = mul_acc;
  assign fix_res  = op_q[2] ? '0 : mul_res;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef MDU_DIV_EN
    sa_d     = sa_q;
    bz_d     = bz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = funct3;
          cnt_d  = CNT_INIT;
          busy_d = 1'b1;
          neg_d  = a_neg ^ b_neg;
          if (funct3[2]) begin
`ifdef MDU_DIV_EN
            opb_d   = mag_b;
            acc_d   = {{XLEN{1'b0}}, mag_a};
            sa_d    = a_neg;
            bz_d    = (src_b == '0);
            state_d = S_RUN;
`else
            state_d = S_FIX;
`endif
          end else begin
            opb_d   = mag_a;
            acc_d   = {{XLEN{1'b0}}, mag_b};
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_res;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MDU_DIV_EN
      sa_q     <= 1'b0;
      bz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MDU_DIV_EN
      sa_q     <= sa_d;
      bz_q     <= bz_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
